// File: rtl/alu_share_ctrl_if.sv
// Requester/response handshake bundle for the shared add/sub controller.
// Latency: none, wiring only.
// Backpressure: carries valid/ready pairs for both requesters and the response.
interface alu_share_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_co;

  // Requesting logic and result consumer
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_co,
    output rsp_ready
  );

  // Controller side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_co,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin controller time-sharing one WIDTH-bit add/sub datapath between two requesters.
// Latency: accept in cycle N, result valid in cycle N+2; one operation per 3 cycles at best.
// Backpressure: result held stable while rsp_ready is low; no new request accepted until it drains.
module alu_share_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_ctrl_if.slave   bus,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] CALC = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             last_grant;
  logic             gnt0;
  logic             gnt1;
  logic             accept;

  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;
  logic             opnd_op;
  logic             opnd_id;
  logic [WIDTH:0]   result;

  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_co_q;
  logic             rsp_id_q;

  // Round-robin grant; readies only in IDLE and held low while reset is asserted
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && (state == IDLE)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign accept         = gnt0 | gnt1;
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  // Shared datapath: extra top bit is carry for add, borrow for subtract
  always_comb begin
    result = '0;
    if (opnd_op) begin
      result = {1'b0, opnd_a} - {1'b0, opnd_b};
    end else begin
      result = {1'b0, opnd_a} + {1'b0, opnd_b};
    end
  end

  // Next-state sequencing: capture -> compute -> hold result until consumed
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture and grant history, updated only on the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      opnd_a     <= '0;
      opnd_b     <= '0;
      opnd_op    <= 1'b0;
      opnd_id    <= 1'b0;
    end else if (accept) begin
      last_grant <= gnt1;
      opnd_id    <= gnt1;
      opnd_a     <= gnt1 ? bus.req1_a  : bus.req0_a;
      opnd_b     <= gnt1 ? bus.req1_b  : bus.req0_b;
      opnd_op    <= gnt1 ? bus.req1_op : bus.req0_op;
    end
  end

  // Result registers load once in CALC and stay stable through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
      rsp_co_q   <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else if (state == CALC) begin
      rsp_data_q <= result[WIDTH-1:0];
      rsp_co_q   <= result[WIDTH];
      rsp_id_q   <= opnd_id;
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_co    = rsp_co_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state != IDLE);

endmodule
